// File: rtl/param_shift_reg.sv
// Parameterised universal shift register: shift/rotate/load/clear with a shift
// counter that pulses done_o once every WIDTH shifts.
module param_shift_reg #(
    parameter int unsigned          WIDTH       = 8,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
    localparam int unsigned         CW          = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             ser_in_l_i,
    input  logic             ser_in_r_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] not_q_o,
    output logic             ser_out_l_o,
    output logic             ser_out_r_o,
    output logic [CW-1:0]    cnt_o,
    output logic             done_o
);

    typedef enum logic [2:0] {
        ModeHold  = 3'b000,
        ModeShl   = 3'b001,
        ModeShr   = 3'b010,
        ModeRol   = 3'b011,
        ModeRor   = 3'b100,
        ModeLoad  = 3'b101,
        ModeAsr   = 3'b110,
        ModeClear = 3'b111
    } mode_e;

    localparam logic [CW-1:0] CntMax = CW'(WIDTH - 1);

    mode_e            mode;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             is_shift;

    assign mode = mode_e'(mode_i);

    always_comb begin
        q_d      = q_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        is_shift = 1'b0;
        if (en_i) begin
            unique case (mode)
                ModeHold: ;
                ModeShl: begin
                    q_d      = {q_q[WIDTH-2:0], ser_in_r_i};
                    is_shift = 1'b1;
                end
                ModeShr: begin
                    q_d      = {ser_in_l_i, q_q[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
                ModeRol: begin
                    q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    is_shift = 1'b1;
                end
                ModeRor: begin
                    q_d      = {q_q[0], q_q[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
                ModeLoad: begin
                    q_d   = d_i;
                    cnt_d = '0;
                end
                ModeAsr: begin
                    q_d      = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
                ModeClear: begin
                    q_d   = RESET_VALUE;
                    cnt_d = '0;
                end
            endcase
            // A shift that completes the word wraps the count and flags done for one cycle.
            if (is_shift) begin
                if (cnt_q == CntMax) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q    <= RESET_VALUE;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign q_o         = q_q;
    assign not_q_o     = ~q_q;
    assign ser_out_l_o = q_q[WIDTH-1];
    assign ser_out_r_o = q_q[0];
    assign cnt_o       = cnt_q;
    assign done_o      = done_q;

endmodule
